// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Multi-cycle radix-2 restoring divider for RV64 M-extension
//               DIV/DIVU/REM/REMU and their 32-bit W variants.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider #(
    parameter int XLEN = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_signed,
    input  logic            in_word,
    input  logic [XLEN-1:0] in_dividend,
    input  logic [XLEN-1:0] in_divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_quotient,
    output logic [XLEN-1:0] out_remainder
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUSY = 2'd1;
    localparam logic [1:0] c_ST_FIX  = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    localparam logic [6:0]      c_N_FULL = 7'(XLEN);
    localparam logic [6:0]      c_N_WORD = 7'd32;
    localparam logic [XLEN-1:0] c_MIN_X  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] c_MIN_W  = {{(XLEN-31){1'b1}}, 31'd0};

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
        return {{(XLEN-32){x[31]}}, x};
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [31:0] x);
        return {{(XLEN-32){1'b0}}, x};
    endfunction

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic [6:0]      r_cnt;
    logic [XLEN:0]   r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_div;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_word;
    logic [XLEN-1:0] r_out_q;
    logic [XLEN-1:0] r_out_r;

    logic [XLEN-1:0] w_a_ext;
    logic [XLEN-1:0] w_b_ext;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_div_zero;
    logic            w_overflow;
    logic            w_special;
    logic            w_accept;
    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_diff;
    logic            w_qbit;
    logic [XLEN-1:0] w_q_signed;
    logic [XLEN-1:0] w_r_signed;
    logic [XLEN-1:0] w_q_fix;
    logic [XLEN-1:0] w_r_fix;

    // Operand preparation: W ops work on the low word, extended per signedness
    always_comb begin
        w_a_ext = in_dividend;
        w_b_ext = in_divisor;
        if (in_word) begin
            w_a_ext = in_signed ? sext32(in_dividend[31:0]) : zext32(in_dividend[31:0]);
            w_b_ext = in_signed ? sext32(in_divisor[31:0])  : zext32(in_divisor[31:0]);
        end
    end

    assign w_a_neg    = in_signed & w_a_ext[XLEN-1];
    assign w_b_neg    = in_signed & w_b_ext[XLEN-1];
    assign w_a_mag    = w_a_neg ? -w_a_ext : w_a_ext;
    assign w_b_mag    = w_b_neg ? -w_b_ext : w_b_ext;
    assign w_div_zero = (w_b_ext == '0);
    assign w_overflow = in_signed & (w_b_ext == '1) &
                        (w_a_ext == (in_word ? c_MIN_W : c_MIN_X));
    assign w_special  = w_div_zero | w_overflow;
    assign w_accept   = (r_state == c_ST_IDLE) & in_valid & ~flush;

    // One restoring step: shift in the next dividend bit, keep difference if non-negative
    assign w_shift = (r_rem << 1) | {{XLEN{1'b0}}, r_quo[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, r_div};
    assign w_qbit  = ~w_diff[XLEN];

    assign w_q_signed = r_neg_q ? -r_quo : r_quo;
    assign w_r_signed = r_neg_r ? -r_rem[XLEN-1:0] : r_rem[XLEN-1:0];
    assign w_q_fix    = r_word ? sext32(w_q_signed[31:0]) : w_q_signed;
    assign w_r_fix    = r_word ? sext32(w_r_signed[31:0]) : w_r_signed;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (in_valid) w_state_next = w_special ? c_ST_DONE : c_ST_BUSY;
            c_ST_BUSY: if (r_cnt <= 7'd1) w_state_next = c_ST_FIX;
            c_ST_FIX:  w_state_next = c_ST_DONE;
            c_ST_DONE: if (out_ready) w_state_next = c_ST_IDLE;
            default:   w_state_next = c_ST_IDLE;
        endcase
        if (flush) w_state_next = c_ST_IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_div   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_word  <= 1'b0;
            r_out_q <= '0;
            r_out_r <= '0;
        end else if (w_accept) begin
            r_rem   <= '0;
            // W ops pre-align the magnitude so the MSB-first loop sees bit 31 first
            r_quo   <= in_word ? (w_a_mag << (XLEN-32)) : w_a_mag;
            r_div   <= w_b_mag;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_word  <= in_word;
            r_cnt   <= w_special ? 7'd0 : (in_word ? c_N_WORD : c_N_FULL);
            if (w_div_zero) begin
                r_out_q <= '1;
                r_out_r <= in_word ? sext32(in_dividend[31:0]) : in_dividend;
            end else if (w_overflow) begin
                r_out_q <= w_a_ext;
                r_out_r <= '0;
            end
        end else if (r_state == c_ST_BUSY) begin
            r_rem <= w_qbit ? w_diff : w_shift;
            r_quo <= {r_quo[XLEN-2:0], w_qbit};
            if (r_cnt != 7'd0) r_cnt <= r_cnt - 7'd1;
        end else if ((r_state == c_ST_FIX) && !flush) begin
            r_out_q <= w_q_fix;
            r_out_r <= w_r_fix;
        end
    end

    assign in_ready      = (r_state == c_ST_IDLE);
    assign out_valid     = (r_state == c_ST_DONE);
    assign out_quotient  = r_out_q;
    assign out_remainder = r_out_r;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_divider
// Description : Self-checking bench for seq_divider against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        in_signed;
    logic        in_word;
    logic [63:0] in_dividend;
    logic [63:0] in_divisor;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_quotient;
    logic [63:0] out_remainder;

    int n_total = 0;
    int n_bad   = 0;

    seq_divider #(.XLEN(64)) dut (
        .clock         (clock),
        .reset         (reset),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_signed     (in_signed),
        .in_word       (in_word),
        .in_dividend   (in_dividend),
        .in_divisor    (in_divisor),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_quotient  (out_quotient),
        .out_remainder (out_remainder)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // RISC-V division semantics from plain signed/unsigned arithmetic
    function automatic void model(input bit s, input bit w, input logic [63:0] a,
                                  input logic [63:0] b, output logic [63:0] q,
                                  output logic [63:0] r, output bit special);
        logic signed [31:0] sa32, sb32, sq32, sr32;
        logic        [31:0] ua32, ub32, uq32, ur32;
        logic signed [63:0] sa64, sb64;
        special = 1'b0;
        if (w) begin
            ua32 = a[31:0];
            ub32 = b[31:0];
            sa32 = a[31:0];
            sb32 = b[31:0];
            if (ub32 == 32'd0) begin
                special = 1'b1;
                uq32 = 32'hFFFF_FFFF;
                ur32 = ua32;
            end else if (s && ua32 == 32'h8000_0000 && ub32 == 32'hFFFF_FFFF) begin
                special = 1'b1;
                uq32 = ua32;
                ur32 = 32'd0;
            end else if (s) begin
                sq32 = sa32 / sb32;
                sr32 = sa32 % sb32;
                uq32 = sq32;
                ur32 = sr32;
            end else begin
                uq32 = ua32 / ub32;
                ur32 = ua32 % ub32;
            end
            q = {{32{uq32[31]}}, uq32};
            r = {{32{ur32[31]}}, ur32};
        end else begin
            sa64 = a;
            sb64 = b;
            if (b == 64'd0) begin
                special = 1'b1;
                q = '1;
                r = a;
            end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
                special = 1'b1;
                q = a;
                r = 64'd0;
            end else if (s) begin
                q = sa64 / sb64;
                r = sa64 % sb64;
            end else begin
                q = a / b;
                r = a % b;
            end
        end
    endfunction

    // Called at posedge+1 while idle; accepts, measures latency, holds, handshakes
    task automatic run_op(input bit s, input bit w, input logic [63:0] a,
                          input logic [63:0] b, input int hold);
        logic [63:0] eq, er;
        bit          sp;
        int          lat;
        int          exp_lat;
        bit          ready_seen;
        model(s, w, a, b, eq, er, sp);
        exp_lat     = sp ? 1 : (w ? 34 : 66);
        in_valid    = 1'b1;
        in_signed   = s;
        in_word     = w;
        in_dividend = a;
        in_divisor  = b;
        out_ready   = 1'b0;
        @(posedge clock);
        #1;
        in_valid    = 1'b0;
        in_dividend = 64'hDEAD_BEEF_DEAD_BEEF;
        in_divisor  = 64'h0;
        lat         = 1;
        ready_seen  = 1'b0;
        while (!out_valid && lat < 200) begin
            if (in_ready) ready_seen = 1'b1;
            @(posedge clock);
            #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(exp_lat));
        check("in_ready_low_busy", 64'(ready_seen), 64'd0);
        check("quotient", out_quotient, eq);
        check("remainder", out_remainder, er);
        repeat (hold) begin
            @(posedge clock);
            #1;
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_quotient", out_quotient, eq);
            check("hold_remainder", out_remainder, er);
        end
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        check("valid_drop", 64'(out_valid), 64'd0);
        check("ready_rise", 64'(in_ready), 64'd1);
    endtask

    initial begin
        reset       = 1'b1;
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_signed   = 1'b0;
        in_word     = 1'b0;
        in_dividend = '0;
        in_divisor  = '0;
        out_ready   = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_quotient", out_quotient, 64'd0);
        check("rst_remainder", out_remainder, 64'd0);

        run_op(1'b0, 1'b0, 64'd100, 64'd7, 0);
        run_op(1'b1, 1'b0, -64'sd100, 64'd7, 0);
        run_op(1'b1, 1'b0, 64'h1234, 64'd0, 0);
        run_op(1'b1, 1'b0, 64'h8000_0000_0000_0000, '1, 0);
        run_op(1'b0, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd2, 0);
        run_op(1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 0);
        run_op(1'b0, 1'b1, 64'h5, 64'd0, 0);
        run_op(1'b0, 0, 64'd1000, 64'd33, 5);

        // Flush mid-BUSY: abandoned, no result ever presented
        in_valid    = 1'b1;
        in_signed   = 1'b0;
        in_word     = 1'b0;
        in_dividend = 64'd12345;
        in_divisor  = 64'd11;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        check("flush_idle", 64'(in_ready), 64'd1);
        begin
            bit valid_seen = 1'b0;
            repeat (80) begin
                @(posedge clock);
                #1;
                if (out_valid) valid_seen = 1'b1;
            end
            check("flush_no_valid", 64'(valid_seen), 64'd0);
        end
        run_op(1'b0, 1'b0, 64'd9, 64'd3, 0);

        // Flush together with a request in IDLE: not accepted
        flush       = 1'b1;
        in_valid    = 1'b1;
        in_dividend = 64'd7;
        in_divisor  = 64'd0;
        @(posedge clock);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_req_ready", 64'(in_ready), 64'd1);
        check("flush_req_valid", 64'(out_valid), 64'd0);

        // Flush beats the output handshake while in DONE
        in_valid   = 1'b1;
        in_signed  = 1'b0;
        in_divisor = 64'd0;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        check("done_before_flush", 64'(out_valid), 64'd1);
        flush     = 1'b1;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        flush     = 1'b0;
        out_ready = 1'b0;
        check("done_flush_valid", 64'(out_valid), 64'd0);
        check("done_flush_ready", 64'(in_ready), 64'd1);

        // Reset mid-BUSY clears everything
        in_valid    = 1'b1;
        in_dividend = 64'd999;
        in_divisor  = 64'd4;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("rst2_in_ready", 64'(in_ready), 64'd1);
        check("rst2_out_valid", 64'(out_valid), 64'd0);
        check("rst2_quotient", out_quotient, 64'd0);
        check("rst2_remainder", out_remainder, 64'd0);

        for (int i = 0; i < 30; i++) begin
            logic [63:0] a, b;
            bit          s, w;
            int          mode;
            s    = 1'($urandom_range(0, 1));
            w    = 1'($urandom_range(0, 1));
            mode = int'($urandom_range(0, 5));
            a    = {$urandom, $urandom} >> $urandom_range(0, 63);
            b    = {$urandom, $urandom} >> $urandom_range(0, 63);
            if ($urandom_range(0, 1) == 1) a = -a;
            case (mode)
                0: b = 64'd0;
                1: begin
                    s = 1'b1;
                    a = w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
                    b = '1;
                end
                2: b = 64'($urandom_range(1, 9));
                default: if ($urandom_range(0, 1) == 1) b = -b;
            endcase
            run_op(s, w, a, b, int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
